// File: rtl/alu_issue_unit.sv
// alu_issue_unit: front end for a 32-bit combinational ALU.
// Buffers tagged commands in a DEPTH-entry FIFO and issues the head to the ALU
// when the response register is free or being drained. The ALU result and zero
// flag are captured into a one-entry response register with the command's tag.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready           command channel handshake (ready = !full, low in reset)
//   cmd_a/cmd_b/cmd_opcode/cmd_tag command payload
//   alu_a/alu_b/alu_opcode        FIFO head to the ALU (zeros while the FIFO is empty)
//   alu_result/alu_zero           combinational ALU outputs
//   rsp_valid/rsp_ready           response channel handshake
//   rsp_result/rsp_zero/rsp_tag   captured response
//   issued_cnt                    commands issued, wraps mod 2^16
module alu_issue_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [2:0]       cmd_opcode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      issued_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StStall} state_e;

  // FIFO storage; contents need no reset since the pointers define occupancy.
  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [2:0]       mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [15:0]      issued_cnt_q, issued_cnt_d;
  state_e           state_q, state_d;

  logic empty, full, push, issue;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // Pointers carry one extra wrap bit to tell full from empty.
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  // No bypass: a command pushed this cycle is only visible to issue next cycle.
  assign issue     = !empty && (!rsp_valid_q || rsp_ready);

  assign alu_a      = empty ? 32'd0 : mem_a[rd_idx];
  assign alu_b      = empty ? 32'd0 : mem_b[rd_idx];
  assign alu_opcode = empty ? 3'd0  : mem_op[rd_idx];

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_tag    = rsp_tag_q;
  assign issued_cnt = issued_cnt_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;
    issued_cnt_d = issued_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (issue) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      rsp_tag_d    = mem_tag[rd_idx];
      issued_cnt_d = issued_cnt_q + 16'd1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Status FSM; it observes the datapath but drives none of it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (push) state_d = StRun;
      end
      StRun: begin
        if (rsp_valid_q && !rsp_ready && !empty) begin
          state_d = StStall;
        end else if (empty && !push && (!rsp_valid_q || rsp_ready)) begin
          state_d = StIdle;
        end
      end
      StStall: begin
        if (rsp_ready) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_idx]   <= cmd_a;
      mem_b[wr_idx]   <= cmd_b;
      mem_op[wr_idx]  <= cmd_opcode;
      mem_tag[wr_idx] <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
      issued_cnt_q <= 16'd0;
      state_q      <= StIdle;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
      issued_cnt_q <= issued_cnt_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU model attached.
module tb_alu_issue_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a, cmd_b;
  logic [2:0]       cmd_opcode;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      alu_a, alu_b;
  logic [2:0]       alu_opcode;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      issued_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational ALU model.
  always_comb begin
    alu_result = 32'd0;
    case (alu_opcode)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      3'd6: alu_result = alu_a << alu_b[4:0];
      default: alu_result = alu_a >> alu_b[4:0];
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  alu_issue_unit #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_opcode (cmd_opcode),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_tag    (rsp_tag),
    .issued_cnt (issued_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [TAG_W-1:0] tag);
    cmd_valid  = 1'b1;
    cmd_a      = a;
    cmd_b      = b;
    cmd_opcode = op;
    cmd_tag    = tag;
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_a      = 32'd0;
    cmd_b      = 32'd0;
    cmd_opcode = 3'd0;
    cmd_tag    = '0;
    rsp_ready  = 1'b1;
    #1;
    check("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_issued", {16'd0, issued_cnt}, 32'd0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_rsp_tag", {28'd0, rsp_tag}, 32'd0);

    // 1: 5 + 3, tag 1
    set_cmd(32'd5, 32'd3, OP_ADD, 4'd1);
    tick();
    cmd_valid = 1'b0;
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_not_yet_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_result", rsp_result, 32'd8);
    check("t1_zero", {31'd0, rsp_zero}, 32'd0);
    check("t1_tag", {28'd0, rsp_tag}, 32'd1);
    check("t1_issued", {16'd0, issued_cnt}, 32'd1);
    tick();
    check("t1_drained", {31'd0, rsp_valid}, 32'd0);

    // 2: 7 - 7 = 0, tag 2
    set_cmd(32'd7, 32'd7, OP_SUB, 4'd2);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t2_valid", {31'd0, rsp_valid}, 32'd1);
    check("t2_result", rsp_result, 32'd0);
    check("t2_zero", {31'd0, rsp_zero}, 32'd1);
    check("t2_tag", {28'd0, rsp_tag}, 32'd2);
    tick();

    // 3: back-pressure, 5 commands tags 3..7, a=10t b=t -> result 11t
    rsp_ready = 1'b0;
    for (int t = 3; t < 8; t++) begin
      set_cmd(32'(10 * t), 32'(t), OP_ADD, 4'(t));
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
    check("t3_valid", {31'd0, rsp_valid}, 32'd1);
    check("t3_head_tag", {28'd0, rsp_tag}, 32'd3);
    tick();
    check("t3_hold_tag", {28'd0, rsp_tag}, 32'd3);
    check("t3_hold_result", rsp_result, 32'd33);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_seq_valid", {31'd0, rsp_valid}, 32'd1);
      check("t3_seq_tag", {28'd0, rsp_tag}, 32'(3 + i));
      check("t3_seq_result", rsp_result, 32'(11 * (3 + i)));
      tick();
    end
    check("t3_drained", {31'd0, rsp_valid}, 32'd0);
    check("t3_ready", {31'd0, cmd_ready}, 32'd1);
    check("t3_issued", {16'd0, issued_cnt}, 32'd7);

    // 4: streaming 20 commands, a=c b=100 tag=c mod 16
    for (int c = 0; c < 20; c++) begin
      set_cmd(32'(c), 32'd100, OP_ADD, 4'(c));
      tick();
      check("t4_never_full", {31'd0, cmd_ready}, 32'd1);
      if (c >= 1) begin
        check("t4_valid", {31'd0, rsp_valid}, 32'd1);
        check("t4_tag", {28'd0, rsp_tag}, 32'((c - 1) % 16));
        check("t4_result", rsp_result, 32'(c - 1 + 100));
      end
    end
    cmd_valid = 1'b0;
    tick();
    check("t4_last_tag", {28'd0, rsp_tag}, 32'd3);
    check("t4_last_result", rsp_result, 32'd119);
    check("t4_issued", {16'd0, issued_cnt}, 32'd27);
    tick();

    // 5: reset with one response held and three queued
    rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      set_cmd(32'(t), 32'd1, OP_ADD, 4'(t + 8));
      tick();
    end
    cmd_valid = 1'b0;
    check("t5_pre_valid", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_issued", {16'd0, issued_cnt}, 32'd0);
    check("t5_ready", {31'd0, cmd_ready}, 32'd1);
    check("t5_alu_a", alu_a, 32'd0);
    rsp_ready = 1'b1;
    tick();
    tick();
    check("t5_no_stale", {31'd0, rsp_valid}, 32'd0);

    // 6: issue 65535 commands then one more to wrap the counter
    set_cmd(32'd0, 32'd0, OP_ADD, 4'd0);
    for (int n = 0; n < 65535; n++) begin
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    check("t6_max", {16'd0, issued_cnt}, 32'h0000_FFFF);
    set_cmd(32'd0, 32'd0, OP_ADD, 4'd5);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t6_wrap", {16'd0, issued_cnt}, 32'd0);
    check("t6_tag", {28'd0, rsp_tag}, 32'd5);
    check("t6_zero", {31'd0, rsp_zero}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
